// File: rtl/ed2platform_cpu_cpu_ocimem_arb.sv
// ed2platform_cpu_cpu_ocimem_arb
// Shares one single-port 256x32 debug RAM between the JTAG monitor command
// path (one pending command) and a CPU slave port. The RAM itself lives
// outside this block; reads return data one cycle after ram_en.
module ed2platform_cpu_cpu_ocimem_arb (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        take_action_ocimem_a,
   input  logic        take_no_action_ocimem_a,
   input  logic        take_action_ocimem_b,
   input  logic [37:0] jdo,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [7:0]  cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic        cpu_ack,
   output logic [31:0] cpu_rdata,
   output logic        ram_en,
   output logic        ram_we,
   output logic [7:0]  ram_addr,
   output logic [31:0] ram_wdata,
   input  logic [31:0] ram_rdata,
   output logic [31:0] MonDReg,
   output logic        monitor_ready,
   output logic        monitor_error
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      JOP  = 3'd1,
      JRD  = 3'd2,
      COP  = 3'd3,
      CRD  = 3'd4
   } state_t;

   localparam logic GRANT_CPU  = 1'b0;
   localparam logic GRANT_JTAG = 1'b1;

   state_t      state_q,      state_d;
   logic        pend_valid_q, pend_valid_d;
   logic        pend_we_q,    pend_we_d;
   logic [31:0] pend_data_q,  pend_data_d;
   logic [7:0]  jaddr_q,      jaddr_d;
   logic        last_grant_q, last_grant_d;
   logic [31:0] mon_dreg_q,   mon_dreg_d;
   logic        ready_q,      ready_d;
   logic        error_q,      error_d;
   logic        cpu_req_q,    cpu_req_d;

   logic        jtag_pulse;
   logic        jtag_go;
   logic        cpu_go;

   // jdo bits outside the address/data/read-flag fields carry nothing here
   logic        unused_jdo;
   assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

   assign jtag_pulse = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
   assign jtag_go    = pend_valid_q;
   // A CPU request must be seen on two consecutive cycles; this also stops a
   // request that drops right after its ack from starting a phantom access.
   assign cpu_go     = cpu_req & cpu_req_q;

   // Command capture, arbitration and sequencing of the shared RAM port
   always_comb begin
      state_d      = state_q;
      pend_valid_d = pend_valid_q;
      pend_we_d    = pend_we_q;
      pend_data_d  = pend_data_q;
      jaddr_d      = jaddr_q;
      last_grant_d = last_grant_q;
      mon_dreg_d   = mon_dreg_q;
      ready_d      = ready_q;
      error_d      = error_q;
      cpu_req_d    = cpu_req;

      // JTAG pulses: anything arriving while a command is pending or in
      // flight (ready low) is discarded and flagged, jaddr load included.
      if (jtag_pulse) begin
         if (!ready_q) begin
            error_d = 1'b1;
         end else if (take_action_ocimem_a) begin
            jaddr_d = jdo[24:17];
            error_d = 1'b0;
            if (jdo[35]) begin
               pend_valid_d = 1'b1;
               pend_we_d    = 1'b0;
               ready_d      = 1'b0;
            end
         end else if (take_no_action_ocimem_a) begin
            pend_valid_d = 1'b1;
            pend_we_d    = 1'b0;
            ready_d      = 1'b0;
         end else begin
            pend_valid_d = 1'b1;
            pend_we_d    = 1'b1;
            pend_data_d  = jdo[34:3];
            ready_d      = 1'b0;
         end
      end

      case (state_q)
         IDLE: begin
            // On a tie, the side that was not granted last wins
            if (jtag_go && (!cpu_go || (last_grant_q == GRANT_CPU))) begin
               state_d      = JOP;
               pend_valid_d = 1'b0;
               last_grant_d = GRANT_JTAG;
            end else if (cpu_go) begin
               state_d      = COP;
               last_grant_d = GRANT_CPU;
            end
         end
         JOP: begin
            if (pend_we_q) begin
               state_d = IDLE;
               jaddr_d = jaddr_q + 8'd1;
               ready_d = 1'b1;
            end else begin
               state_d = JRD;
            end
         end
         JRD: begin
            state_d    = IDLE;
            mon_dreg_d = ram_rdata;
            jaddr_d    = jaddr_q + 8'd1;
            ready_d    = 1'b1;
         end
         COP: begin
            state_d = cpu_we ? IDLE : CRD;
         end
         CRD: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // RAM port and CPU response decode from the current state
   always_comb begin
      cpu_ack   = 1'b0;
      cpu_rdata = 32'h0;
      ram_en    = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = 8'h0;
      ram_wdata = 32'h0;
      case (state_q)
         JOP: begin
            ram_en    = 1'b1;
            ram_we    = pend_we_q;
            ram_addr  = jaddr_q;
            ram_wdata = pend_data_q;
         end
         COP: begin
            ram_en    = 1'b1;
            ram_we    = cpu_we;
            ram_addr  = cpu_addr;
            ram_wdata = cpu_wdata;
            cpu_ack   = cpu_we;
         end
         CRD: begin
            cpu_ack   = 1'b1;
            cpu_rdata = ram_rdata;
         end
         default: begin
         end
      endcase
   end

   // State registers; reset abandons any access in flight
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         pend_valid_q <= 1'b0;
         pend_we_q    <= 1'b0;
         pend_data_q  <= 32'h0;
         jaddr_q      <= 8'h0;
         last_grant_q <= GRANT_CPU;
         mon_dreg_q   <= 32'h0;
         ready_q      <= 1'b1;
         error_q      <= 1'b0;
         cpu_req_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         pend_valid_q <= pend_valid_d;
         pend_we_q    <= pend_we_d;
         pend_data_q  <= pend_data_d;
         jaddr_q      <= jaddr_d;
         last_grant_q <= last_grant_d;
         mon_dreg_q   <= mon_dreg_d;
         ready_q      <= ready_d;
         error_q      <= error_d;
         cpu_req_q    <= cpu_req_d;
      end
   end

   assign MonDReg       = mon_dreg_q;
   assign monitor_ready = ready_q;
   assign monitor_error = error_q;

endmodule

// File: tb/tb_ed2platform_cpu_cpu_ocimem_arb.sv
// Testbench for ed2platform_cpu_cpu_ocimem_arb: directed vector table plus
// hand-written sequences for arbitration ties, dropped commands and reset.
// A JTAG pulse or CPU request is driven 1ns after edge N; "e" counts the
// edges that follow, outputs are sampled 1ns after each of them.
module tb_ed2platform_cpu_cpu_ocimem_arb;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        take_action_ocimem_a;
   logic        take_no_action_ocimem_a;
   logic        take_action_ocimem_b;
   logic [37:0] jdo;
   logic        cpu_req;
   logic        cpu_we;
   logic [7:0]  cpu_addr;
   logic [31:0] cpu_wdata;
   logic        cpu_ack;
   logic [31:0] cpu_rdata;
   logic        ram_en;
   logic        ram_we;
   logic [7:0]  ram_addr;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata;
   logic [31:0] mon_dreg;
   logic        monitor_ready;
   logic        monitor_error;

   int tests = 0;
   int fails = 0;

   ed2platform_cpu_cpu_ocimem_arb dut (
      .clk                     (clk),
      .reset_n                 (reset_n),
      .take_action_ocimem_a    (take_action_ocimem_a),
      .take_no_action_ocimem_a (take_no_action_ocimem_a),
      .take_action_ocimem_b    (take_action_ocimem_b),
      .jdo                     (jdo),
      .cpu_req                 (cpu_req),
      .cpu_we                  (cpu_we),
      .cpu_addr                (cpu_addr),
      .cpu_wdata               (cpu_wdata),
      .cpu_ack                 (cpu_ack),
      .cpu_rdata               (cpu_rdata),
      .ram_en                  (ram_en),
      .ram_we                  (ram_we),
      .ram_addr                (ram_addr),
      .ram_wdata               (ram_wdata),
      .ram_rdata               (ram_rdata),
      .MonDReg                 (mon_dreg),
      .monitor_ready           (monitor_ready),
      .monitor_error           (monitor_error)
   );

   always #5 clk = ~clk;

   // Debug RAM model: 256x32, one-cycle registered read
   logic [31:0] mem [256];
   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we) mem[ram_addr] <= ram_wdata;
         ram_rdata <= mem[ram_addr];
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end else begin
         $display("[TB] ok %s = %h", name, act);
      end
   endtask

   // kind: 2 ocimem_a with read, 3 ocimem_a address only, 4 no_action read, 5 ocimem_b write
   task automatic jtag_run(input int kind, input logic [7:0] addr, input logic [31:0] data,
                           output int lat, output logic en_seen, output logic [7:0] en_addr);
      logic [37:0] j;
      j = '0;
      case (kind)
         2: begin j[35] = 1'b1; j[24:17] = addr; end
         3: j[24:17] = addr;
         5: j[34:3] = data;
         default: ;
      endcase
      jdo = j;
      take_action_ocimem_a    = (kind == 2) || (kind == 3);
      take_no_action_ocimem_a = (kind == 4);
      take_action_ocimem_b    = (kind == 5);
      lat = 99; en_seen = 1'b0; en_addr = 8'h0;
      for (int e = 1; e <= 20; e++) begin
         @(posedge clk); #1;
         if (e == 1) begin
            take_action_ocimem_a    = 1'b0;
            take_no_action_ocimem_a = 1'b0;
            take_action_ocimem_b    = 1'b0;
         end
         if (ram_en && !en_seen) begin en_seen = 1'b1; en_addr = ram_addr; end
         if (monitor_ready) begin lat = e; break; end
      end
   endtask

   task automatic cpu_run(input logic we, input logic [7:0] addr, input logic [31:0] wd,
                          output int lat, output logic en_seen, output logic [7:0] en_addr,
                          output logic [31:0] rd);
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
      lat = 99; en_seen = 1'b0; en_addr = 8'h0; rd = 32'h0;
      for (int e = 1; e <= 20; e++) begin
         @(posedge clk); #1;
         if (ram_en && !en_seen) begin en_seen = 1'b1; en_addr = ram_addr; end
         if (cpu_ack) begin lat = e; rd = cpu_rdata; break; end
      end
      @(posedge clk); #1;
      cpu_req = 1'b0;
      @(posedge clk); #1;
   endtask

   // JTAG no_action read and CPU read of 0x20 issued in the same cycle
   task automatic tie_run(output int ack_e, output int rdy_e, output logic [7:0] a1,
                          output logic [7:0] a2, output logic [31:0] rd);
      int   n_en;
      logic drop;
      n_en = 0; drop = 1'b0;
      jdo = '0; take_no_action_ocimem_a = 1'b1;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h20;
      ack_e = 99; rdy_e = 99; a1 = 8'h0; a2 = 8'h0; rd = 32'h0;
      for (int e = 1; e <= 20; e++) begin
         @(posedge clk); #1;
         if (e == 1) take_no_action_ocimem_a = 1'b0;
         if (drop) begin cpu_req = 1'b0; drop = 1'b0; end
         if (ram_en) begin
            if (n_en == 0) a1 = ram_addr;
            else if (n_en == 1) a2 = ram_addr;
            n_en++;
         end
         if (cpu_ack && ack_e == 99) begin ack_e = e; rd = cpu_rdata; drop = 1'b1; end
         if (monitor_ready && rdy_e == 99) rdy_e = e;
         if (ack_e != 99 && rdy_e != 99 && !drop) break;
      end
      cpu_req = 1'b0;
      @(posedge clk); #1;
   endtask

   typedef struct {
      int          kind;     // 0 cpu write, 1 cpu read, 2..5 jtag (see jtag_run)
      logic [7:0]  addr;
      logic [31:0] data;
      int          exp_lat;
      logic        exp_en;
      logic [7:0]  exp_addr;
      logic [31:0] exp_rd;
      logic        chk_rd;
   } vec_t;

   vec_t        vecs [12];
   int          lat, ack_e, rdy_e, en_cnt, idx, last;
   logic        en_seen, upd;
   logic [7:0]  en_addr, a1, a2;
   logic [31:0] rd;
   logic [7:0]  bb_addr [4];
   logic [31:0] bb_exp  [4];
   logic [37:0] jtmp;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0]  = '{0, 8'h10, 32'hDEADBEEF, 2, 1'b1, 8'h10, 32'h0,        1'b0};
      vecs[1]  = '{0, 8'h20, 32'hCAFEF00D, 2, 1'b1, 8'h20, 32'h0,        1'b0};
      vecs[2]  = '{0, 8'h00, 32'hA5A5A5A5, 2, 1'b1, 8'h00, 32'h0,        1'b0};
      vecs[3]  = '{0, 8'h02, 32'h02020202, 2, 1'b1, 8'h02, 32'h0,        1'b0};
      vecs[4]  = '{2, 8'h10, 32'h0,        4, 1'b1, 8'h10, 32'hDEADBEEF, 1'b1};
      vecs[5]  = '{5, 8'h00, 32'h11111111, 3, 1'b1, 8'h11, 32'h0,        1'b0};
      vecs[6]  = '{1, 8'h11, 32'h0,        3, 1'b1, 8'h11, 32'h11111111, 1'b1};
      vecs[7]  = '{1, 8'h20, 32'h0,        3, 1'b1, 8'h20, 32'hCAFEF00D, 1'b1};
      vecs[8]  = '{3, 8'hFF, 32'h0,        1, 1'b0, 8'h00, 32'h0,        1'b0};
      vecs[9]  = '{5, 8'h00, 32'h12345678, 3, 1'b1, 8'hFF, 32'h0,        1'b0};
      vecs[10] = '{4, 8'h00, 32'h0,        4, 1'b1, 8'h00, 32'hA5A5A5A5, 1'b1};
      vecs[11] = '{1, 8'hFF, 32'h0,        3, 1'b1, 8'hFF, 32'h12345678, 1'b1};
      bb_addr[0] = 8'h10; bb_exp[0] = 32'hDEADBEEF;
      bb_addr[1] = 8'h20; bb_exp[1] = 32'hCAFEF00D;
      bb_addr[2] = 8'h11; bb_exp[2] = 32'h11111111;
      bb_addr[3] = 8'hFF; bb_exp[3] = 32'h12345678;

      reset_n = 1'b0;
      take_action_ocimem_a = 1'b0; take_no_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0;
      jdo = '0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h0; cpu_wdata = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_mondreg", mon_dreg, 32'h0);
      chk("rst_ready", {31'h0, monitor_ready}, 32'h1);
      chk("rst_error", {31'h0, monitor_error}, 32'h0);
      chk("rst_cpu_ack", {31'h0, cpu_ack}, 32'h0);
      chk("rst_ram_en", {31'h0, ram_en}, 32'h0);
      @(negedge clk); reset_n = 1'b1;
      @(posedge clk); #1;

      // Directed vector table
      for (int i = 0; i < 12; i++) begin
         if (vecs[i].kind <= 1)
            cpu_run(vecs[i].kind == 0, vecs[i].addr, vecs[i].data, lat, en_seen, en_addr, rd);
         else
            jtag_run(vecs[i].kind, vecs[i].addr, vecs[i].data, lat, en_seen, en_addr);
         $display("[TB] vec %0d kind %0d lat %0d en %0b addr %h", i, vecs[i].kind, lat, en_seen, en_addr);
         chk($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
         chk($sformatf("v%0d_ram_en", i), {31'h0, en_seen}, {31'h0, vecs[i].exp_en});
         if (vecs[i].exp_en) chk($sformatf("v%0d_ram_addr", i), {24'h0, en_addr}, {24'h0, vecs[i].exp_addr});
         if (vecs[i].chk_rd) begin
            if (vecs[i].kind == 1) chk($sformatf("v%0d_cpu_rdata", i), rd, vecs[i].exp_rd);
            else                   chk($sformatf("v%0d_mondreg", i), mon_dreg, vecs[i].exp_rd);
         end
      end
      chk("ram_ff_written", mem[8'hFF], 32'h12345678);

      // Back-to-back CPU reads, request held high throughout
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = bb_addr[0];
      idx = 0; last = 0; en_cnt = 0; upd = 1'b0;
      for (int e = 1; e <= 40 && idx < 4; e++) begin
         @(posedge clk); #1;
         if (upd) begin cpu_addr = bb_addr[idx]; upd = 1'b0; end
         if (ram_en) en_cnt++;
         if (cpu_ack) begin
            $display("[TB] b2b read %0d ack at edge %0d data %h", idx, e, cpu_rdata);
            chk($sformatf("bb%0d_rdata", idx), cpu_rdata, bb_exp[idx]);
            chk($sformatf("bb%0d_spacing", idx), e - last, 3);
            last = e; idx++;
            if (idx < 4) upd = 1'b1;
         end
      end
      @(posedge clk); #1; cpu_req = 1'b0;
      if (ram_en) en_cnt++;
      repeat (2) begin @(posedge clk); #1; if (ram_en) en_cnt++; end
      chk("bb_acks", idx, 4);
      chk("bb_ram_en_cycles", en_cnt, 4);

      // Second ocimem_b one cycle after the first: first completes, second dropped
      jtmp = '0; jtmp[34:3] = 32'h0BAD0001;
      jdo = jtmp; take_action_ocimem_b = 1'b1;
      @(posedge clk); #1;
      jtmp = '0; jtmp[34:3] = 32'h0BAD0002; jdo = jtmp;
      @(posedge clk); #1;
      take_action_ocimem_b = 1'b0;
      chk("drop_jop_wdata", ram_wdata, 32'h0BAD0001);
      chk("drop_jop_addr", {24'h0, ram_addr}, 32'h00000001);
      chk("drop_error_set", {31'h0, monitor_error}, 32'h1);
      en_cnt = 0; lat = 99;
      for (int e = 1; e <= 10; e++) begin
         if (ram_en) en_cnt++;
         @(posedge clk); #1;
         if (monitor_ready) begin lat = e; break; end
      end
      repeat (2) begin @(posedge clk); #1; if (ram_en) en_cnt++; end
      $display("[TB] dropped-write sequence: ready after %0d, ram_en cycles %0d", lat, en_cnt);
      chk("drop_ready_edge", lat, 1);
      chk("drop_one_access", en_cnt, 1);
      chk("drop_ram_word", mem[8'h01], 32'h0BAD0001);
      jtag_run(4, 8'h0, 32'h0, lat, en_seen, en_addr);
      chk("drop_next_addr", {24'h0, en_addr}, 32'h00000002);
      chk("drop_next_mondreg", mon_dreg, 32'h02020202);
      chk("drop_error_sticky", {31'h0, monitor_error}, 32'h1);
      jtag_run(3, 8'h40, 32'h0, lat, en_seen, en_addr);
      chk("drop_error_cleared", {31'h0, monitor_error}, 32'h0);

      // Reset asserted during the JOP cycle of a JTAG write
      cpu_run(1'b1, 8'h40, 32'h40404040, lat, en_seen, en_addr, rd);
      jtmp = '0; jtmp[34:3] = 32'h99999999;
      jdo = jtmp; take_action_ocimem_b = 1'b1;
      @(posedge clk); #1; take_action_ocimem_b = 1'b0;
      @(posedge clk); #1;
      chk("rst_mid_pre_en", {31'h0, ram_en}, 32'h1);
      chk("rst_mid_pre_addr", {24'h0, ram_addr}, 32'h00000040);
      #2 reset_n = 1'b0;
      #1;
      chk("rst_mid_ram_en", {31'h0, ram_en}, 32'h0);
      chk("rst_mid_ram_we", {31'h0, ram_we}, 32'h0);
      chk("rst_mid_ready", {31'h0, monitor_ready}, 32'h1);
      chk("rst_mid_cpu_ack", {31'h0, cpu_ack}, 32'h0);
      chk("rst_mid_mondreg", mon_dreg, 32'h0);
      @(negedge clk); reset_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_mid_no_write", mem[8'h40], 32'h40404040);

      // Tie straight after reset: JTAG wins (jaddr back at 0), CPU follows
      tie_run(ack_e, rdy_e, a1, a2, rd);
      $display("[TB] tie1 first %h second %h ack %0d ready %0d", a1, a2, ack_e, rdy_e);
      chk("tie1_first_addr", {24'h0, a1}, 32'h00000000);
      chk("tie1_second_addr", {24'h0, a2}, 32'h00000020);
      chk("tie1_ready_edge", rdy_e, 4);
      chk("tie1_ack_edge", ack_e, 6);
      chk("tie1_mondreg", mon_dreg, 32'hA5A5A5A5);
      chk("tie1_cpu_rdata", rd, 32'hCAFEF00D);

      // JTAG-only write leaves JTAG as last grant; next tie goes to the CPU
      jtag_run(5, 8'h0, 32'h77777777, lat, en_seen, en_addr);
      chk("tie_mid_addr", {24'h0, en_addr}, 32'h00000001);
      tie_run(ack_e, rdy_e, a1, a2, rd);
      $display("[TB] tie2 first %h second %h ack %0d ready %0d", a1, a2, ack_e, rdy_e);
      chk("tie2_first_addr", {24'h0, a1}, 32'h00000020);
      chk("tie2_second_addr", {24'h0, a2}, 32'h00000002);
      chk("tie2_ack_edge", ack_e, 3);
      chk("tie2_ready_edge", rdy_e, 7);
      chk("tie2_mondreg", mon_dreg, 32'h02020202);
      chk("tie2_cpu_rdata", rd, 32'hCAFEF00D);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ed2platform_cpu_cpu_ocimem_arb.md
ED2PLATFORM_CPU_CPU_OCIMEM_ARB -- requirements
Module: ed2platform_cpu_cpu_ocimem_arb

Interface
REQ-001 SHALL have ports (name direction width meaning), clock and reset first:
- clk  in  1  system clock; one clock domain, all state on rising edge
- reset_n  in  1  reset, asynchronous, active-low
- take_action_ocimem_a  in  1  JTAG pulse: load address, optional read
- take_no_action_ocimem_a  in  1  JTAG pulse: read at current address
- take_action_ocimem_b  in  1  JTAG pulse: write at current address
- jdo  in  38  JTAG data: [35] read flag, [34:3] write data, [24:17] address
- cpu_req  in  1  CPU access request, level, held until cpu_ack
- cpu_we  in  1  CPU write (1) / read (0), valid with cpu_req
- cpu_addr  in  8  CPU word address
- cpu_wdata  in  32  CPU write data
- cpu_ack  out  1  CPU access complete, one-cycle pulse
- cpu_rdata  out  32  CPU read data, valid with cpu_ack on reads
- ram_en  out  1  debug RAM enable
- ram_we  out  1  debug RAM write enable
- ram_addr  out  8  debug RAM word address
- ram_wdata  out  32  debug RAM write data
- ram_rdata  in  32  debug RAM read data, one cycle after ram_en
- MonDReg  out  32  last JTAG read data
- monitor_ready  out  1  JTAG command idle/complete
- monitor_error  out  1  sticky: JTAG command dropped
REQ-002 SHALL have no parameters; RAM depth fixed at 256 x 32.

Function
REQ-003 SHALL share one single-port debug RAM between a JTAG command path and a CPU slave path.
REQ-004 SHALL hold one pending JTAG command (type, data) in a 1-deep register; command pulses are single-cycle and at most one is asserted per cycle.
REQ-005 SHALL, on take_action_ocimem_a: jaddr <= jdo[24:17]; if jdo[35]=1, pend a read, else no RAM access.
REQ-006 SHALL, on take_no_action_ocimem_a: pend a read at jaddr; on take_action_ocimem_b: pend a write of jdo[34:3] at jaddr.
REQ-007 SHALL increment jaddr by 1 after each completed JTAG read or write; 8'hFF wraps to 8'h00.
REQ-008 SHALL, on any command pulse while a JTAG command is pending or in progress, drop it (no state change except jaddr load per REQ-005 is also dropped) and set monitor_error=1.
REQ-009 SHALL clear monitor_error only on an accepted take_action_ocimem_a.
REQ-010 SHALL drive monitor_ready=0 from the edge after an accepted pulse until completion.
REQ-011 SHALL use FSM states IDLE, JOP, JRD, COP, CRD.
REQ-012 IDLE: if exactly one of {JTAG pending, cpu_req} -> that side's OP; if both -> side not granted last (last_grant reset = CPU, so JTAG wins first tie); else stay.
REQ-013 JOP/COP: ram_en=1, ram_we/addr/wdata from the granted source; write -> IDLE; read -> JRD/CRD.
REQ-014 JRD: MonDReg <= ram_rdata at end of cycle; -> IDLE. CRD: cpu_rdata = ram_rdata, cpu_ack=1; -> IDLE.
REQ-015 CPU write: cpu_ack=1 during COP.
REQ-016 ram_en=0 and ram_we=0 in IDLE, JRD, CRD.
REQ-017 Latency, uncontended JTAG read, pulse sampled at edge N: JOP after edge N+2, MonDReg and monitor_ready=1 at edge N+4; write: monitor_ready=1 at edge N+3.
REQ-018 Latency, uncontended CPU: read cpu_ack 3 cycles after cpu_req rises, write 2 cycles after.
REQ-019 A read at address A issued by JTAG SHALL return data written by a CPU write to A that completed earlier, and vice versa.

Reset
REQ-020 SHALL, on reset_n=0 at any time including mid-operation, asynchronously force: state IDLE, pending cleared, jaddr=0, last_grant=CPU, MonDReg=0, monitor_ready=1, monitor_error=0, cpu_ack=0, ram_en=0, ram_we=0; interrupted accesses are abandoned without ack.

Verification
REQ-021 Bench SHALL cover:
- ocimem_a jdo[24:17]=8'h10, jdo[35]=1, RAM[0x10]=32'hDEADBEEF -> MonDReg=32'hDEADBEEF, monitor_ready=1 at edge N+4, jaddr=8'h11.
- jaddr=8'hFF, ocimem_b data 32'h12345678 -> RAM[0xFF] written, jaddr=8'h00; no_action_a then reads RAM[0x00].
- cpu_req read addr 0x20 and JTAG read pulse same cycle, fresh reset -> JTAG granted first, cpu_ack follows after JRD; second tie grants CPU.
- Second ocimem_b one cycle after first -> first write completes, second dropped, monitor_error=1; next ocimem_a clears it.
- reset_n low during JOP of a write -> ram_en=0 immediately, monitor_ready=1, jaddr=0, no cpu_ack.
- Back-to-back CPU reads with no JTAG -> cpu_ack every 3 cycles, ram_en never asserted in IDLE.
